// File: rtl/audio_fifo_bram_ctrl_if.sv
// Bus bundle for the audio sample FIFO: APB-side write, DAC-side stream, BRAM ports.
// No latency of its own; pure wiring.
// The stream half uses valid/ready. The write half relies on fifo_full to drop writes.
interface audio_fifo_bram_ctrl_if #(
  parameter int data_width = 32,
  parameter int depth      = 1024
);
  localparam int aw = $clog2(depth - 1) + 1;

  logic                  flush;
  logic                  fifo_wen;
  logic [data_width-1:0] fifo_din;
  logic                  fifo_full;
  logic [data_width-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [aw:0]           level;
  logic                  almost_empty;
  logic                  bram_wen;
  logic [aw-1:0]         bram_waddr;
  logic [data_width-1:0] bram_wdata;
  logic                  bram_ren;
  logic [aw-1:0]         bram_raddr;
  logic [data_width-1:0] bram_rdata;

  // Controller view
  modport slave (
    input  flush, fifo_wen, fifo_din, m_ready, bram_rdata,
    output fifo_full, m_data, m_valid, level, almost_empty,
           bram_wen, bram_waddr, bram_wdata, bram_ren, bram_raddr
  );

  // Environment view: register bank, DAC shifter and BRAM
  modport master (
    output flush, fifo_wen, fifo_din, m_ready, bram_rdata,
    input  fifo_full, m_data, m_valid, level, almost_empty,
           bram_wen, bram_waddr, bram_wdata, bram_ren, bram_raddr
  );
endinterface

// File: rtl/audio_fifo_bram_ctrl.sv
// Circular-buffer controller over a simple dual-port BRAM, with read prefetch and a skid FIFO.
// First-word latency is bram_read_la+2 clk from write to m_valid. Sustained rate is 1 word/clk.
// m_ready low stops BRAM reads once skid+in-flight fills. Writes are dropped while fifo_full.
module audio_fifo_bram_ctrl #(
  parameter int data_width      = 32,
  parameter int depth           = 1024,
  parameter int bram_read_la    = 2,
  parameter int almost_empty_th = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  audio_fifo_bram_ctrl_if.slave bus
);
  localparam int AW  = $clog2(depth - 1) + 1;
  localparam int LA  = bram_read_la;
  localparam int SD  = bram_read_la + 1;          // skid depth covers every read in flight
  localparam int CW  = $clog2(SD + 1);
  localparam int SIW = (SD > 1) ? $clog2(SD) : 1;
  localparam int OW  = CW + 1;
  localparam int LW  = AW + 1;

  logic [AW-1:0]         wptr, rptr, ram_cnt;
  logic [LA-1:0]         inflight;
  logic [CW-1:0]         skid_cnt;
  logic [data_width-1:0] skid_mem [SD];
  logic                  fifo_full_q;
  logic [LW-1:0]         level_q;
  logic                  almost_empty_q;

  logic                  wr_acc, pop, push, issue;
  logic [OW-1:0]         inflight_cnt, inflight_cnt_nxt, occ;
  logic [AW-1:0]         ram_cnt_nxt;
  logic [LA-1:0]         inflight_nxt;
  logic [CW-1:0]         skid_cnt_nxt;
  logic [SIW-1:0]        skid_wr_idx;
  logic [LW-1:0]         level_nxt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(depth - 1)) ? '0 : p + AW'(1);
  endfunction

  // flush masks every transfer in its own cycle, so a write or pop there is lost.
  assign wr_acc = bus.fifo_wen & ~fifo_full_q & ~bus.flush;
  assign pop    = (skid_cnt != '0) & bus.m_ready & ~bus.flush;
  assign push   = inflight[LA-1] & ~bus.flush;

  assign bus.bram_wen     = wr_acc;
  assign bus.bram_waddr   = wptr;
  assign bus.bram_wdata   = bus.fifo_din;
  assign bus.bram_ren     = issue;
  assign bus.bram_raddr   = rptr;
  assign bus.fifo_full    = fifo_full_q;
  assign bus.m_valid      = (skid_cnt != '0);
  assign bus.m_data       = skid_mem[0];
  assign bus.level        = level_q;
  assign bus.almost_empty = almost_empty_q;

  // Issue a read only when the skid has a free slot for it after every word already in flight lands.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < LA; i++) inflight_cnt = inflight_cnt + OW'(inflight[i]);
    occ          = OW'(skid_cnt) + inflight_cnt - OW'(pop);
    issue        = (ram_cnt != '0) & ~bus.flush & (occ < OW'(SD));
    ram_cnt_nxt  = ram_cnt + AW'(wr_acc) - AW'(issue);
    skid_cnt_nxt = skid_cnt + CW'(push) - CW'(pop);
    inflight_nxt = (inflight << 1) | LA'(issue);
    if (bus.flush) begin
      ram_cnt_nxt  = '0;
      skid_cnt_nxt = '0;
      inflight_nxt = '0;
    end
    inflight_cnt_nxt = '0;
    for (int i = 0; i < LA; i++) inflight_cnt_nxt = inflight_cnt_nxt + OW'(inflight_nxt[i]);
    level_nxt   = LW'(ram_cnt_nxt) + LW'(inflight_cnt_nxt) + LW'(skid_cnt_nxt);
    skid_wr_idx = SIW'(skid_cnt - CW'(pop));
  end

  // Pointers, counters and the registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr           <= '0;
      rptr           <= '0;
      ram_cnt        <= '0;
      inflight       <= '0;
      skid_cnt       <= '0;
      fifo_full_q    <= 1'b0;
      level_q        <= '0;
      almost_empty_q <= 1'b1;
    end else begin
      if (bus.flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc) wptr <= ptr_inc(wptr);
        if (issue)  rptr <= ptr_inc(rptr);
      end
      ram_cnt        <= ram_cnt_nxt;
      inflight       <= inflight_nxt;
      skid_cnt       <= skid_cnt_nxt;
      fifo_full_q    <= (ram_cnt_nxt == AW'(depth));
      level_q        <= level_nxt;
      almost_empty_q <= (level_nxt <= LW'(almost_empty_th));
    end
  end

  // Skid storage: entry 0 is the head. A pop shifts down, and a push lands behind the survivors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SD; i++) skid_mem[i] <= '0;
    end else if (!bus.flush) begin
      if (pop) begin
        for (int i = 0; i < SD - 1; i++) skid_mem[i] <= skid_mem[i+1];
      end
      if (push) skid_mem[skid_wr_idx] <= bus.bram_rdata;
    end
  end

  // A push into a full skid without a pop would lose a word.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (skid_cnt == CW'(SD))));

endmodule
